pdm_frame_unpack: RTL and testbench
===================================

Name: pdm_frame_unpack

Overview:
- Receive-side counterpart of the PDM-to-UART streamer.
- Consumes bytes from the UART receiver, one strobe per byte. Each byte is {3-bit channel id, 5-bit accumulator}.
- Reassembles the 4-byte frame, sent in the order id 3 (sum), id 2 (diff), id 1, id 0, into four parallel 5-bit channel values with a frame-valid strobe.
- Detects sequence errors and inter-byte timeouts, resynchronises, and reports lock status for the bench/host-side FPGA loopback.

Parameters:
- TIMEOUT_CYCLES, 1024: max clk cycles allowed between bytes inside a frame. Must be ≥2.
- LOCK_FRAMES, 4: consecutive good frames required to assert locked. Must be ≥1.
- ERR_BITS, 16: width of the saturating error counter.

Ports:
- clk  in  1  system clock (PLL clock domain)
- rst_n  in  1  synchronous, active-low reset
- rx_byte  in  8  received byte; sampled only when rx_valid=1
- rx_valid  in  1  single-cycle byte strobe
- ch_sum  out  5  payload of id 3
- ch_diff  out  5  payload of id 2
- ch1  out  5  payload of id 1
- ch0  out  5  payload of id 0
- frame_valid  out  1  1-cycle pulse; all channel outputs updated together
- frame_err  out  1  1-cycle pulse per detected error
- err_count  out  ERR_BITS  saturating count of errors
- locked  out  1  stream aligned

Behaviour:
- Reset:
  - On rst_n=0 at posedge clk, all outputs become 0.
  - FSM goes to HUNT; timer, good-frame counter and payload holding registers clear.
  - Reset mid-frame discards the partial frame; no pulse is emitted.
- Byte fields: id = rx_byte[7:5], data = rx_byte[4:0]. Ids 4..7 are always errors, except in HUNT, where they are ignored silently.
- FSM states: HUNT, EXP2, EXP1, EXP0.
  - HUNT: rx_valid with id 3 → hold data as sum, go to EXP2. Any other id → stay in HUNT, no error.
  - EXP2: id 2 → hold diff, go to EXP1.
  - EXP1: id 1 → hold ch1, go to EXP0.
  - EXP0: id 0 → commit. ch_sum/ch_diff/ch1 are loaded from the holding registers and ch0 from the current byte, all on the same edge. frame_valid=1 for the cycle after that edge (registered, latency 1). Go to HUNT.
  - Wrong id in EXP2/EXP1/EXP0 → error. If the offending id is 3, treat it as the start of a new frame: hold sum, go to EXP2. Otherwise go to HUNT.
- Channel outputs hold their values between commits; partial frames never change them.
- Timeout:
  - The timer runs only in EXP2/EXP1/EXP0. It clears on every rx_valid and on entry to HUNT.
  - If the timer reaches TIMEOUT_CYCLES-1 with no rx_valid that cycle → error, go to HUNT.
  - rx_valid in the expiring cycle takes priority; no timeout is raised.
- Error handling:
  - Each error gives exactly one frame_err pulse, in the cycle after detection.
  - err_count increments by 1 and saturates at all-ones (no wrap).
  - At most one error per cycle.
- Lock:
  - The good-frame counter increments on each commit and saturates at LOCK_FRAMES.
  - locked=1 when the count equals LOCK_FRAMES.
  - Any error clears the counter and deasserts locked in the same cycle as the frame_err pulse.
- Back-to-back: rx_valid on consecutive cycles must be accepted without loss.
- frame_valid and frame_err are never asserted together.

Test Plan:
- Reset, then bytes 0x63,0x4A,0x31,0x1F → ch_sum=0x03, ch_diff=0x0A, ch1=0x11, ch0=0x1F; frame_valid high exactly one cycle, starting the cycle after the 0x1F strobe; err_count=0.
- Four clean frames back-to-back (rx_valid every cycle) → four frame_valid pulses; locked rises with the 4th pulse. A fifth frame keeps locked=1.
- While locked, send 0x63,0x4A,0x0F (id 0 where id 1 expected) → one frame_err pulse; err_count=1; locked=0; outputs unchanged; FSM in HUNT.
- Send 0x63,0x4A,0x7C (id 3 mid-frame),0x45,0x22,0x01 → one error, then a commit with ch_sum=0x1C, ch_diff=0x05, ch1=0x02, ch0=0x01.
- Send 0x63, then idle 1023 cycles → frame_err exactly once, FSM in HUNT. Repeat, but strobe 0x4A exactly in the expiring cycle → no error; the frame continues.
- Force err_count to all-ones with ERR_BITS=4 (15 errors), then inject a 16th → stays 0xF. Assert rst_n=0 mid-frame after 0x63,0x4A, then send a clean frame → all outputs 0 after reset; next frame commits normally with no spurious pulse.

Source files
------------

// File: rtl/pdm_frame_unpack.sv
// pdm_frame_unpack: rebuilds 4-byte PDM frames {id[2:0], data[4:0]} from a
// UART byte stream (order id 3, 2, 1, 0) into four parallel 5-bit channels.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   rx_byte, rx_valid received byte and its single-cycle strobe
//   ch_sum, ch_diff,  channel payloads of ids 3, 2, 1, 0; updated together
//   ch1, ch0          on a commit and held otherwise
//   frame_valid       1-cycle pulse after a frame commits
//   frame_err         1-cycle pulse after a sequence error or timeout
//   err_count         saturating error counter
//   locked            LOCK_FRAMES consecutive good frames seen since last error
module pdm_frame_unpack #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int LOCK_FRAMES    = 4,
    parameter int ERR_BITS       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          rx_byte,
    input  logic                rx_valid,
    output logic [4:0]          ch_sum,
    output logic [4:0]          ch_diff,
    output logic [4:0]          ch1,
    output logic [4:0]          ch0,
    output logic                frame_valid,
    output logic                frame_err,
    output logic [ERR_BITS-1:0] err_count,
    output logic                locked
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int GW = $clog2(LOCK_FRAMES + 1);

    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] G_MAX  = GW'(LOCK_FRAMES);

    localparam logic [1:0] HUNT = 2'd0;
    localparam logic [1:0] EXP2 = 2'd1;
    localparam logic [1:0] EXP1 = 2'd2;
    localparam logic [1:0] EXP0 = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [GW-1:0]       good_q, good_d;
    logic [4:0]          hsum_q, hsum_d;
    logic [4:0]          hdiff_q, hdiff_d;
    logic [4:0]          h1_q, h1_d;
    logic [4:0]          sum_q, diff_q, c1_q, c0_q;
    logic                fv_q, fe_q;
    logic [ERR_BITS-1:0] ecnt_q;

    logic [2:0] id;
    logic [4:0] data;
    logic [2:0] exp_id;
    logic       commit;
    logic       err;

    assign id   = rx_byte[7:5];
    assign data = rx_byte[4:0];

    always_comb begin
        exp_id = 3'd0;
        case (state_q)
            EXP2:    exp_id = 3'd2;
            EXP1:    exp_id = 3'd1;
            default: exp_id = 3'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        hsum_d  = hsum_q;
        hdiff_d = hdiff_q;
        h1_d    = h1_q;
        commit  = 1'b0;
        err     = 1'b0;

        if (state_q == HUNT) begin
            // Anything but a frame start is dropped silently while hunting.
            if (rx_valid && id == 3'd3) begin
                hsum_d  = data;
                state_d = EXP2;
            end
        end else if (rx_valid) begin
            if (id == exp_id) begin
                case (state_q)
                    EXP2: begin
                        hdiff_d = data;
                        state_d = EXP1;
                    end
                    EXP1: begin
                        h1_d    = data;
                        state_d = EXP0;
                    end
                    default: begin
                        commit  = 1'b1;
                        state_d = HUNT;
                    end
                endcase
            end else begin
                err = 1'b1;
                // A stray id 3 is most likely the start of the next frame.
                if (id == 3'd3) begin
                    hsum_d  = data;
                    state_d = EXP2;
                end else begin
                    state_d = HUNT;
                end
            end
        end else if (timer_q == T_LAST) begin
            err     = 1'b1;
            state_d = HUNT;
        end
    end

    always_comb begin
        timer_d = timer_q + TW'(1);
        if (rx_valid || state_d == HUNT || state_q == HUNT) begin
            timer_d = '0;
        end
    end

    always_comb begin
        good_d = good_q;
        if (err) begin
            good_d = '0;
        end else if (commit && good_q != G_MAX) begin
            good_d = good_q + GW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HUNT;
            timer_q <= '0;
            good_q  <= '0;
            hsum_q  <= '0;
            hdiff_q <= '0;
            h1_q    <= '0;
            sum_q   <= '0;
            diff_q  <= '0;
            c1_q    <= '0;
            c0_q    <= '0;
            fv_q    <= 1'b0;
            fe_q    <= 1'b0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            good_q  <= good_d;
            hsum_q  <= hsum_d;
            hdiff_q <= hdiff_d;
            h1_q    <= h1_d;
            fv_q    <= commit;
            fe_q    <= err;
            if (commit) begin
                sum_q  <= hsum_q;
                diff_q <= hdiff_q;
                c1_q   <= h1_q;
                c0_q   <= data;
            end
            if (err && !(&ecnt_q)) begin
                ecnt_q <= ecnt_q + ERR_BITS'(1);
            end
        end
    end

    assign ch_sum      = sum_q;
    assign ch_diff     = diff_q;
    assign ch1         = c1_q;
    assign ch0         = c0_q;
    assign frame_valid = fv_q;
    assign frame_err   = fe_q;
    assign err_count   = ecnt_q;
    assign locked      = (good_q == G_MAX);

endmodule

// File: tb/tb_pdm_frame_unpack.sv
// tb_pdm_frame_unpack: directed bench for the PDM frame unpacker.
// Uses ERR_BITS=4 so counter saturation is reachable quickly.
module tb_pdm_frame_unpack;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [4:0] ch_sum, ch_diff, ch1, ch0;
    logic       frame_valid, frame_err, locked;
    logic [3:0] err_count;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pdm_frame_unpack #(
        .TIMEOUT_CYCLES(1024),
        .LOCK_FRAMES(4),
        .ERR_BITS(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_byte(rx_byte),
        .rx_valid(rx_valid),
        .ch_sum(ch_sum),
        .ch_diff(ch_diff),
        .ch1(ch1),
        .ch0(ch0),
        .frame_valid(frame_valid),
        .frame_err(frame_err),
        .err_count(err_count),
        .locked(locked)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic check_ch(input string tag, input logic [4:0] s,
                            input logic [4:0] d, input logic [4:0] c1,
                            input logic [4:0] c0);
        check({tag, ".sum"}, ch_sum, s);
        check({tag, ".diff"}, ch_diff, d);
        check({tag, ".ch1"}, ch1, c1);
        check({tag, ".ch0"}, ch0, c0);
    endtask

    task automatic check_zero(input string tag);
        check_ch(tag, 5'h0, 5'h0, 5'h0, 5'h0);
        check({tag, ".fv"}, frame_valid, 0);
        check({tag, ".fe"}, frame_err, 0);
        check({tag, ".ecnt"}, err_count, 0);
        check({tag, ".lock"}, locked, 0);
    endtask

    int pulses;
    int errs;
    int first;

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        tick();
        tick();
        check_zero("reset");
        rst_n = 1'b1;

        // Single clean frame
        pulses = 0;
        send(8'h63); pulses += int'(frame_valid);
        send(8'h4A); pulses += int'(frame_valid);
        send(8'h31); pulses += int'(frame_valid);
        check("f1.early_fv", pulses, 0);
        send(8'h1F);
        check("f1.fv", frame_valid, 1);
        check_ch("f1", 5'h03, 5'h0A, 5'h11, 5'h1F);
        check("f1.ecnt", err_count, 0);
        tick();
        check("f1.fv_off", frame_valid, 0);

        // Lock count from zero: four back-to-back frames, then a fifth
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            send(8'h60 | 8'(k));
            pulses += int'(frame_valid);
            send(8'h40 | 8'(k + 8));
            pulses += int'(frame_valid);
            send(8'h20 | 8'(k + 16));
            pulses += int'(frame_valid);
            send(8'(k + 24));
            pulses += int'(frame_valid);
            if (k == 2) check("b2b.lock3", locked, 0);
            if (k == 3) begin
                check("b2b.pulses4", pulses, 4);
                check("b2b.lock4", locked, 1);
            end
        end
        check("b2b.pulses5", pulses, 5);
        check("b2b.lock5", locked, 1);
        check_ch("b2b", 5'h04, 5'h0C, 5'h14, 5'h1C);

        // Wrong id while locked
        send(8'h63);
        send(8'h4A);
        send(8'h0F);
        check("seq.fe", frame_err, 1);
        check("seq.fv", frame_valid, 0);
        check("seq.ecnt", err_count, 1);
        check("seq.lock", locked, 0);
        check_ch("seq", 5'h04, 5'h0C, 5'h14, 5'h1C);
        send(8'h22);
        check("seq.hunt", frame_err, 0);

        // Mid-frame id 3 restarts the frame
        send(8'h63);
        send(8'h4A);
        send(8'h7C);
        check("restart.fe", frame_err, 1);
        check("restart.ecnt", err_count, 2);
        send(8'h45);
        send(8'h22);
        send(8'h01);
        check("restart.fv", frame_valid, 1);
        check("restart.fe_off", frame_err, 0);
        check_ch("restart", 5'h1C, 5'h05, 5'h02, 5'h01);

        // Timeout: expires on the 1024th edge after the strobe
        send(8'h63);
        errs  = 0;
        first = 0;
        for (int i = 1; i <= 1100; i++) begin
            tick();
            if (frame_err) begin
                errs++;
                if (first == 0) first = i;
            end
        end
        check("to.count", errs, 1);
        check("to.cycle", first, 1024);
        check("to.ecnt", err_count, 3);
        send(8'h4A);
        check("to.hunt", frame_err, 0);

        // Byte arriving in the expiring cycle wins
        send(8'h63);
        errs = 0;
        for (int i = 1; i <= 1023; i++) begin
            tick();
            errs += int'(frame_err);
        end
        send(8'h4A);
        errs += int'(frame_err);
        check("tolast.noerr", errs, 0);
        send(8'h31);
        send(8'h1F);
        check("tolast.fv", frame_valid, 1);
        check_ch("tolast", 5'h03, 5'h0A, 5'h11, 5'h1F);
        check("tolast.ecnt", err_count, 3);

        // Saturate the 4-bit error counter
        for (int i = 0; i < 12; i++) begin
            send(8'h63);
            send(8'h0F);
        end
        check("sat.ecnt15", err_count, 15);
        send(8'h63);
        send(8'h0F);
        check("sat.fe", frame_err, 1);
        check("sat.ecnt16", err_count, 15);

        // Reset mid-frame, then a clean frame
        send(8'h63);
        send(8'h4A);
        rst_n = 1'b0;
        tick();
        check_zero("midrst");
        rst_n = 1'b1;
        pulses = 0;
        errs   = 0;
        send(8'h6A);
        pulses += int'(frame_valid); errs += int'(frame_err);
        send(8'h55);
        pulses += int'(frame_valid); errs += int'(frame_err);
        send(8'h3E);
        pulses += int'(frame_valid); errs += int'(frame_err);
        check("post.early_fv", pulses, 0);
        check("post.early_fe", errs, 0);
        send(8'h01);
        check("post.fv", frame_valid, 1);
        check_ch("post", 5'h0A, 5'h15, 5'h1E, 5'h01);
        check("post.ecnt", err_count, 0);
        check("post.lock", locked, 0);
        tick();
        check("post.fv_off", frame_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
